adder_seq_ctrl: RTL and testbench

//  Sequencer that performs WIDTH-bit additions on one shared 4-bit `adder` slice,
//  one nibble per cycle, least significant nibble first.
//  - Inter-nibble carry is chained through a register.
//  - Operands arrive and results leave over valid/ready handshakes.
//  - Sits between an operand producer and a result consumer, with the 4-bit adder instantiated inside.

---
 rtl/adder_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_adder_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder: one shared 4-bit slice, LSB nibble first, carry chained through a register.
// Optional signed-overflow output enabled by defining ADDER_SEQ_OVF_EN.
module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0, c_in};
endmodule

module adder_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
`ifdef ADDER_SEQ_OVF_EN
    ,
    output logic             out_ovf
`endif
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
    logic              carry_q, carry_d;
    logic              out_valid_q, out_valid_d;
    logic              out_cout_q, out_cout_d;
    logic [3:0]        slice_a, slice_b, slice_sum;
    logic              slice_cout;
`ifdef ADDER_SEQ_OVF_EN
    logic              out_ovf_q, out_ovf_d;
`endif

    // carry_q is preloaded with in_cin at acceptance, so it is the slice carry-in for every nibble
    adder u_adder (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_cout_d  = out_cout_q;
`ifdef ADDER_SEQ_OVF_EN
        out_ovf_d   = out_ovf_q;
`endif
        slice_a     = a_q[4*idx_q +: 4];
        slice_b     = b_q[4*idx_q +: 4];
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[4*idx_q +: 4] = slice_sum;
                carry_d                = slice_cout;
                idx_d                  = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NIB - 1)) begin
                    idx_d       = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_cout_d  = slice_cout;
`ifdef ADDER_SEQ_OVF_EN
                    out_ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[3] != a_q[WIDTH-1]);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_cout_q  <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_cout_q  <= out_cout_d;
`ifdef ADDER_SEQ_OVF_EN
            out_ovf_q   <= out_ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_sum   = result_q;
    assign out_cout  = out_cout_q;
`ifdef ADDER_SEQ_OVF_EN
    assign out_ovf   = out_ovf_q;
`endif
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl (WIDTH=16) against an arithmetic reference model.
module tb_adder_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_cin;
    logic [WIDTH-1:0] in_a, in_b, out_sum;
    logic             out_valid, out_ready, out_cout, busy;
    logic             out_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
`ifdef ADDER_SEQ_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

`ifndef ADDER_SEQ_OVF_EN
    assign out_ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait for result, hold out_ready low, then consume.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                         input int hold, input bit scramble, input string name);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] es;
        logic             ec, eo;
        int               n;
        full = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
        es   = full[WIDTH-1:0];
        ec   = full[WIDTH];
        eo   = (a[WIDTH-1] == b[WIDTH-1]) && (es[WIDTH-1] != a[WIDTH-1]);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept_timeout in_ready=%b required 1", name, in_ready);
        end
        step();
        in_valid = 1'b0;
        if (scramble) begin
            in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_cin = 1'($urandom);
        end
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        n_checks++;
        if (n !== NIB) begin
            n_fail++;
            $display("FAIL %s latency got=%0d required=%0d", name, n, NIB);
        end
        n_checks++;
        if (out_sum !== es || out_cout !== ec) begin
            n_fail++;
            $display("FAIL %s result sum=%h cout=%b required sum=%h cout=%b", name, out_sum, out_cout, es, ec);
        end
`ifdef ADDER_SEQ_OVF_EN
        n_checks++;
        if (out_ovf !== eo) begin
            n_fail++;
            $display("FAIL %s ovf got=%b required=%b", name, out_ovf, eo);
        end
`endif
        for (int i = 0; i < hold; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== es || out_cout !== ec || in_ready !== 1'b0 ||
                out_ovf !== ((eo === 1'b1) && (out_ovf === 1'b1) ? 1'b1 : out_ovf)) begin
                n_fail++;
                $display("FAIL %s hold%0d valid=%b sum=%h cout=%b in_ready=%b required valid=1 sum=%h cout=%b in_ready=0",
                         name, i, out_valid, out_sum, out_cout, in_ready, es, ec);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s consume valid=%b in_ready=%b required valid=0 in_ready=1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b1; out_ready = 1'b0;
        step(); step();
        in_valid = 1'b0;
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_sum !== '0 ||
            out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset valid=%b ready=%b busy=%b sum=%h cout=%b ovf=%b required 0 1 0 0000 0 0",
                     out_valid, in_ready, busy, out_sum, out_cout, out_ovf);
        end
        // out_ready high while nothing is valid must do nothing
        out_ready = 1'b1;
        step(); step();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_out_ready valid=%b ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_basic();
        do_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0, "t1_carry_chain");
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "t2_wrap");
        do_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0, "t2_cin_only");
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1, 1'b0, "max_plus_cin");
    endtask

    task automatic test_hold();
        do_op(16'h1234, 16'h4321, 1'b0, 5, 1'b1, "t3_hold");
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_s[2];
        logic             exp_c[2];
        int               accepts, got;
        bit               acc_now, take;
        exp_s[0] = 16'h0002; exp_c[0] = 1'b0;
        exp_s[1] = 16'h0000; exp_c[1] = 1'b1;
        in_a = 16'h0001; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        accepts = 0; got = 0;
        for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
            if (busy && in_ready) begin
                n_checks++; n_fail++;
                $display("FAIL b2b ready_while_busy cycle=%0d busy=1 in_ready=1 required in_ready=0", cyc);
            end
            acc_now = in_valid && in_ready;
            take    = out_valid && out_ready;
            if (take) begin
                n_checks++;
                if (out_sum !== exp_s[got] || out_cout !== exp_c[got]) begin
                    n_fail++;
                    $display("FAIL b2b result%0d sum=%h cout=%b required sum=%h cout=%b",
                             got, out_sum, out_cout, exp_s[got], exp_c[got]);
                end
                got++;
            end
            step();
            if (acc_now) begin
                accepts++;
                if (accepts == 1) begin in_a = 16'h8000; in_b = 16'h8000; end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (accepts !== 2 || got !== 2) begin
            n_fail++;
            $display("FAIL b2b counts accepts=%0d results=%0d required 2 2", accepts, got);
        end
    endtask

    task automatic test_reset_mid();
        in_a = 16'hFFFF; in_b = 16'h0001; in_cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid valid=%b ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
        end
        do_op(16'h000F, 16'h0001, 1'b0, 0, 1'b0, "t5_after_reset");
        // reset asserted on the same edge as a would-be handshake
        in_valid = 1'b1; rst_n = 1'b0;
        step();
        in_valid = 1'b0; rst_n = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_vs_accept busy=%b ready=%b required 0 1", busy, in_ready);
        end
    endtask

    task automatic test_ovf();
        do_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, "t6_pos_ovf");
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "t6_no_ovf");
        do_op(16'h8000, 16'hFFFF, 1'b0, 0, 1'b0, "t6_neg_ovf");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                  1'($urandom), "random");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_ovf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
